// File: rtl/mem_to_uart_tx_pkg.sv
// Shared 8N1 UART frame constants, baud helper and TX FSM state encoding.
// The matching receiver imports the same package.
package mem_to_uart_tx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   BIT_CNT_W  = $clog2(DATA_BITS);
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   CLK_HZ     = 100_000_000;

    // Rounded clk cycles per bit for a given baud rate
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } tx_state_e;

endpackage

// File: rtl/mem_to_uart_tx_timer.sv
// UART bit timer: bit_done pulses every CLKS_PER_BIT cycles; restart
// reloads the count so every bit period is measured from state entry.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || bit_done)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_to_uart_tx.sv
// Streams a ROWS x COLS byte matrix from synchronous-read memory out over
// an 8N1 UART line, row-major, one frame per element.
module mem_to_uart_tx
    import mem_to_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int ROWS         = 2,
    parameter int COLS         = 2,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(ROWS * COLS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     index;
    logic [DATA_BITS-1:0]  shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_done;
    logic                  timer_restart;

    // Any state change restarts the timer, so each bit starts at count 0
    assign timer_restart = (state_d != state_q);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (timer_restart),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_START;
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA:  if (bit_done && bit_cnt == LAST_BIT) state_d = S_STOP;
            S_STOP:  if (bit_done) state_d = (index == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        if (state_q == S_FETCH) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = index;
        end
    end

    // tx is registered; each bit's level is loaded on the edge that enters it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= IDLE_LEVEL;
        end else begin
            case (state_q)
                S_IDLE: if (start) index <= '0;
                S_WAIT: begin
                    shreg <= mem_rd_data;
                    tx    <= ~IDLE_LEVEL;
                end
                S_START: if (bit_done) begin
                    tx      <= shreg[0];
                    bit_cnt <= '0;
                end
                S_DATA: if (bit_done) begin
                    shreg <= shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        tx <= IDLE_LEVEL;
                    end else begin
                        tx      <= shreg[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: if (bit_done && index != LAST_IDX) index <= index + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_to_uart_tx.sv
// Randomized scoreboard bench for mem_to_uart_tx: a transfer-level model
// queues expected reads, frames and done pulses; monitors decode the line.
module tb_mem_to_uart_tx;

    localparam int CPB   = 4;
    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int FRAME = 2 + 10 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_b;
    logic       mem_rd_en, mem_rd_en_b;
    logic [5:0] mem_rd_addr, mem_rd_addr_b;
    logic [7:0] rd_data, rd_data_b;
    logic       tx, busy, done, tx_b, busy_b, done_b;
    logic [7:0] mem [4];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {int val; int at;} exp_t;
    exp_t q_addr[$], q_byte[$], q_done[$], qb_addr[$], qb_done[$];
    int cur_c0 = 0, cur_d = -1, next_ok = 0;

    mem_to_uart_tx #(.CLKS_PER_BIT(CPB), .ROWS(ROWS), .COLS(COLS), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(rd_data),
        .tx(tx), .busy(busy), .done(done)
    );

    mem_to_uart_tx #(.CLKS_PER_BIT(CPB), .ROWS(1), .COLS(3), .ADDR_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_rd_en(mem_rd_en_b),
        .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(rd_data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) rd_data <= mem[mem_rd_addr[1:0]];
    always @(posedge clk) if (mem_rd_en_b) rd_data_b <= mem[mem_rd_addr_b[1:0]];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Transfer model: a start seen while idle reads every element once,
    // 2+10*CPB clk per element, then one DONE cycle.
    task automatic step(input logic s);
        @(negedge clk);
        start = s;
        if (s && !rst && cyc + 1 >= next_ok) begin
            cur_c0 = cyc + 1;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    int i;
                    i = r * COLS + c;
                    q_addr.push_back('{i, cur_c0 + i * FRAME});
                    q_byte.push_back('{int'(mem[i]), cur_c0 + i * FRAME + 2});
                end
            cur_d = cur_c0 + ROWS * COLS * FRAME;
            q_done.push_back('{0, cur_d});
            next_ok = cur_d + 2;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && cyc + 1 < next_ok; i++) step(1'b0);
        chk("idle_reached", int'(cyc + 1 >= next_ok), 1);
    endtask

    // Read-strobe, done and busy monitor
    exp_t e_m;
    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (q_addr.size() == 0) chk("unexpected_rd", int'(mem_rd_en), 0);
            else begin
                e_m = q_addr.pop_front();
                chk("rd_addr", int'(mem_rd_addr), e_m.val);
                chk("rd_cycle", cyc, e_m.at);
            end
        end
        if (done) begin
            if (q_done.size() == 0) chk("unexpected_done", int'(done), 0);
            else begin
                e_m = q_done.pop_front();
                chk("done_cycle", cyc, e_m.at);
            end
        end
        chk("busy", int'(busy), int'(cyc >= cur_c0 && cyc <= cur_d));
    end

    // Serial decoder: frame anchored at the start-bit fall; each bit must
    // hold one level for exactly CPB samples, and the line is high after stop.
    logic       in_frame = 1'b0;
    logic       shape_ok;
    logic [9:0] lvl;
    int         k, fall_at;
    exp_t       e_f;
    always @(negedge clk) begin
        if (rst) in_frame = 1'b0;
        else if (in_frame) begin
            if (k == 10 * CPB) begin
                in_frame = 1'b0;
                chk("post_stop_high", int'(tx), 1);
                chk("stop_bit", int'(lvl[9]), 1);
                chk("bit_shape", int'(shape_ok), 1);
                if (q_byte.size() == 0) chk("unexpected_frame_at", fall_at, -1);
                else begin
                    e_f = q_byte.pop_front();
                    chk("tx_byte", int'(lvl[8:1]), e_f.val);
                    chk("start_fall_cycle", fall_at, e_f.at);
                end
            end else begin
                if (k % CPB == 0) lvl[k / CPB] = tx;
                else if (tx != lvl[k / CPB]) shape_ok = 1'b0;
                k++;
            end
        end else if (tx == 1'b0) begin
            in_frame = 1'b1;
            fall_at  = cyc;
            shape_ok = 1'b1;
            lvl      = '0;
            k        = 1;
        end
    end

    // Monitor for the 1x3 instance
    exp_t e_b;
    always @(negedge clk) begin
        if (mem_rd_en_b) begin
            if (qb_addr.size() == 0) chk("b_unexpected_rd", int'(mem_rd_en_b), 0);
            else begin
                e_b = qb_addr.pop_front();
                chk("b_rd_addr", int'(mem_rd_addr_b), e_b.val);
                chk("b_rd_cycle", cyc, e_b.at);
            end
        end
        if (done_b) begin
            if (qb_done.size() == 0) chk("b_unexpected_done", int'(done_b), 0);
            else begin
                e_b = qb_done.pop_front();
                chk("b_done_cycle", cyc, e_b.at);
            end
        end
    end

    initial begin
        int c0, c0b;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
        rst = 1'b1; start = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(mem_rd_en), 0);
        chk("rst_rd_addr", int'(mem_rd_addr), 0);
        chk("rst_b_tx", int'(tx_b), 1);
        rst = 1'b0;

        // Idle with no start
        repeat (100) step(1'b0);
        chk("idle_tx", int'(tx), 1);

        // Single start pulse
        step(1'b1);
        wait_idle();

        // Start held high across back-to-back transfers
        for (int i = 0; i < 2 * ROWS * COLS * FRAME + 4; i++) step(1'b1);
        step(1'b0);
        wait_idle();

        // Random start pulses, mostly landing while busy
        for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 15) == 0));
        wait_idle();

        // Reset during bit 3 of element 1
        step(1'b1);
        c0 = cur_c0;
        while (cyc < c0 + FRAME + 2 + 4 * CPB + 1) step(1'($urandom_range(0, 1)));
        start = 1'b0;
        #1 rst = 1'b1;
        q_addr.delete(); q_byte.delete(); q_done.delete();
        cur_d = -1; next_ok = 0;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b1);
        wait_idle();

        // Random memory contents
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            step(1'b1);
            wait_idle();
        end
        repeat (5) step(1'b0);

        // 1x3 variant
        @(negedge clk);
        start_b = 1'b1;
        c0b = cyc + 1;
        for (int i = 0; i < 3; i++) qb_addr.push_back('{i, c0b + i * FRAME});
        qb_done.push_back('{0, c0b + 3 * FRAME});
        @(negedge clk);
        start_b = 1'b0;
        repeat (3 * FRAME + 10) @(negedge clk);
        chk("b_idle_tx", int'(tx_b), 1);
        chk("b_idle_busy", int'(busy_b), 0);

        chk("pending_rd", q_addr.size(), 0);
        chk("pending_byte", q_byte.size(), 0);
        chk("pending_done", q_done.size(), 0);
        chk("b_pending_rd", qb_addr.size(), 0);
        chk("b_pending_done", qb_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
